// File: rtl/uart_tx.sv
// UART transmitter: start bit, 7/8 data bits LSB first, optional parity, 1/2 stop bits, 8 baud rates.
// Optional feature: define UART_TX_BREAK_EN to add a break_req input that holds the line low.
module uart_tx #(
  parameter int CLK_HZ = 100_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [2:0] clk_mode,
  input  logic       data_size,
  input  logic       parity_en,
  input  logic [1:0] parity_mode,
  input  logic       stop_bit_size,
  input  logic [7:0] data,
  input  logic       send,
`ifdef UART_TX_BREAK_EN
  input  logic       break_req,
`endif
  output logic       ready,
  output logic       tx,
  output logic       uartClock
);

  localparam int DW = $clog2(CLK_HZ / 9600 + 1);

  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP
`ifdef UART_TX_BREAK_EN
    , BRK, BRK_REC
`endif
  } state_t;

  state_t        state, state_n;
  logic [DW-1:0] div_cnt, div_len;
  logic [2:0]    bit_cnt;
  logic [7:0]    cfg_data;
  logic          cfg_size, cfg_par_en, cfg_stop2;
  logic [1:0]    cfg_par_mode;
  logic [2:0]    cfg_mode;
  logic          bit_done, accept, par_bit;
  logic [2:0]    last_bit;

  function automatic logic [DW-1:0] div_of(input logic [2:0] mode);
    case (mode)
      3'd0:    div_of = DW'(CLK_HZ / 9600);
      3'd1:    div_of = DW'(CLK_HZ / 19200);
      3'd2:    div_of = DW'(CLK_HZ / 38400);
      3'd3:    div_of = DW'(CLK_HZ / 57600);
      3'd4:    div_of = DW'(CLK_HZ / 115200);
      3'd5:    div_of = DW'(CLK_HZ / 230400);
      3'd6:    div_of = DW'(CLK_HZ / 460800);
      default: div_of = DW'(CLK_HZ / 921600);
    endcase
  endfunction

  assign div_len  = div_of(cfg_mode);
  assign bit_done = (div_cnt == div_len - DW'(1));
  assign last_bit = cfg_size ? 3'd7 : 3'd6;

  // cfg_data is masked to 7 bits at accept, so the XOR covers only the bits actually sent.
  always_comb begin
    case (cfg_par_mode)
      2'b11:   par_bit = ~^cfg_data;
      2'b10:   par_bit = ^cfg_data;
      2'b01:   par_bit = 1'b1;
      default: par_bit = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_n;
  end

  // NOTE: every output of this block gets a default first so no path leaves one unassigned (no latches).
  always_comb begin
    state_n = state;
    accept  = 1'b0;
    ready   = 1'b0;
    tx      = 1'b1;
    case (state)
      IDLE: begin
        ready = 1'b1;
`ifdef UART_TX_BREAK_EN
        if (break_req) begin
          ready   = 1'b0;
          tx      = 1'b0;
          state_n = BRK;
        end else
`endif
        if (send && en) begin
          accept  = 1'b1;
          state_n = START;
        end
      end
      START: begin
        tx = 1'b0;
        if (bit_done) state_n = DATA;
      end
      DATA: begin
        tx = cfg_data[bit_cnt];
        if (bit_done && bit_cnt == last_bit) state_n = cfg_par_en ? PARITY : STOP;
      end
      PARITY: begin
        tx = par_bit;
        if (bit_done) state_n = STOP;
      end
      STOP: begin
        if (bit_done && (!cfg_stop2 || bit_cnt[0])) state_n = IDLE;
      end
`ifdef UART_TX_BREAK_EN
      BRK: begin
        tx = 1'b0;
        if (!break_req) state_n = BRK_REC;
      end
      BRK_REC: begin
        if (bit_done) state_n = IDLE;
      end
`endif
      default: state_n = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      div_cnt      <= '0;
      bit_cnt      <= '0;
      cfg_data     <= '0;
      cfg_size     <= 1'b0;
      cfg_par_en   <= 1'b0;
      cfg_par_mode <= '0;
      cfg_stop2    <= 1'b0;
      cfg_mode     <= '0;
    end else begin
      if (state == IDLE || bit_done
`ifdef UART_TX_BREAK_EN
          || state == BRK
`endif
         )
        div_cnt <= '0;
      else
        div_cnt <= div_cnt + DW'(1);

      if (state_n != state)
        bit_cnt <= '0;
      else if (bit_done && (state == DATA || state == STOP))
        bit_cnt <= bit_cnt + 3'd1;

      if (accept) begin
        cfg_data     <= data_size ? data : {1'b0, data[6:0]};
        cfg_size     <= data_size;
        cfg_par_en   <= parity_en;
        cfg_par_mode <= parity_mode;
        cfg_stop2    <= stop_bit_size;
        cfg_mode     <= clk_mode;
      end
`ifdef UART_TX_BREAK_EN
      if (state == IDLE && state_n == BRK) cfg_mode <= clk_mode;
`endif
    end
  end

  // Bit-rate clock: high for the first half of every bit period, quiet while idle.
  always_comb begin
    uartClock = 1'b0;
    if (state != IDLE
`ifdef UART_TX_BREAK_EN
        && state != BRK
`endif
       )
      uartClock = (div_cnt < (div_len >> 1));
  end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: expected frames are queued when send is driven and
// compared bit by bit (first and last cycle of each bit), with frame length and bit clock.
module tb_uart_tx;

  localparam int CLK_HZ = 100_000_000;

  typedef struct {
    logic [2:0] mode;
    logic [7:0] data;
    logic       size;
    logic       par_en;
    logic [1:0] par_mode;
    logic       stop2;
  } cfg_t;

  logic       clk = 1'b0;
  logic       rst, en, data_size, parity_en, stop_bit_size, send;
  logic [2:0] clk_mode;
  logic [1:0] parity_mode;
  logic [7:0] data;
  logic       ready, tx, uart_clock;
`ifdef UART_TX_BREAK_EN
  logic       break_req = 1'b0;
`endif

  int asserts = 0;
  int fails   = 0;

  logic exp_bits[$];
  int   exp_len[$];
  int   exp_nb[$];

  always #5 clk = ~clk;

  uart_tx #(.CLK_HZ(CLK_HZ)) dut (
    .clk(clk), .rst(rst), .en(en), .clk_mode(clk_mode), .data_size(data_size),
    .parity_en(parity_en), .parity_mode(parity_mode), .stop_bit_size(stop_bit_size),
    .data(data), .send(send),
`ifdef UART_TX_BREAK_EN
    .break_req(break_req),
`endif
    .ready(ready), .tx(tx), .uartClock(uart_clock)
  );

  function automatic int div_of(input logic [2:0] m);
    int baud[8] = '{9600, 19200, 38400, 57600, 115200, 230400, 460800, 921600};
    return CLK_HZ / baud[m];
  endfunction

  task automatic drive_cfg(input cfg_t c);
    clk_mode = c.mode; data = c.data; data_size = c.size;
    parity_en = c.par_en; parity_mode = c.par_mode; stop_bit_size = c.stop2;
  endtask

  task automatic scramble();
    clk_mode = 3'($urandom); data = 8'($urandom); data_size = 1'($urandom);
    parity_en = 1'($urandom); parity_mode = 2'($urandom); stop_bit_size = 1'($urandom);
  endtask

  task automatic push_frame(input cfg_t c);
    int n, ones, nb;
    logic par;
    n = c.size ? 8 : 7;
    ones = 0;
    exp_bits.push_back(1'b0);
    for (int i = 0; i < n; i++) begin
      exp_bits.push_back(c.data[i]);
      ones += int'(c.data[i]);
    end
    nb = 1 + n;
    if (c.par_en) begin
      case (c.par_mode)
        2'b11:   par = (ones % 2 == 0);
        2'b10:   par = (ones % 2 == 1);
        2'b01:   par = 1'b1;
        default: par = 1'b0;
      endcase
      exp_bits.push_back(par);
      nb++;
    end
    exp_bits.push_back(1'b1);
    nb++;
    if (c.stop2) begin
      exp_bits.push_back(1'b1);
      nb++;
    end
    exp_nb.push_back(nb);
    exp_len.push_back(nb * div_of(c.mode));
  endtask

  // Observes one frame from the first low tx sample until ready returns; records tx and
  // uartClock on the first and last cycle of each bit period. Makes no judgement itself.
  task automatic capture(input int div, output logic [11:0] fst, output logic [11:0] lst,
                         output logic [11:0] ufst, output logic [11:0] ulst,
                         output int len, output bit to);
    int c;
    fst = '1; lst = '0; ufst = '0; ulst = '1; len = 0; to = 1'b0;
    c = 0;
    while (tx !== 1'b0 && c < 50) begin
      @(negedge clk);
      c++;
    end
    if (tx !== 1'b0) begin
      to = 1'b1;
      return;
    end
    c = 0;
    while (ready !== 1'b1 && c < 6000) begin
      if (c / div < 12) begin
        if (c % div == 0)       begin fst[c / div] = tx; ufst[c / div] = uart_clock; end
        if (c % div == div - 1) begin lst[c / div] = tx; ulst[c / div] = uart_clock; end
      end
      @(negedge clk);
      c++;
    end
    len = c;
    if (ready !== 1'b1) to = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0; en = 1'b1; send = 1'b1;
    drive_cfg('{3'd6, 8'h95, 1'b1, 1'b0, 2'b00, 1'b0});
    repeat (3) @(negedge clk);
    asserts++;
    if (tx !== 1'b1) begin fails++; $display("FAIL reset_tx: got %b expected 1", tx); end
    asserts++;
    if (ready !== 1'b1) begin fails++; $display("FAIL reset_ready: got %b expected 1", ready); end
    asserts++;
    if (uart_clock !== 1'b0) begin fails++; $display("FAIL reset_uartclock: got %b expected 0", uart_clock); end
    send = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_frames();
    cfg_t tbl[$];
    logic [11:0] fst, lst, ufst, ulst;
    logic [11:0] m;
    int len, nb, el;
    bit to;
    logic eb;
    tbl.push_back('{3'd6, 8'h95, 1'b1, 1'b0, 2'b00, 1'b0});
    tbl.push_back('{3'd6, 8'h95, 1'b1, 1'b1, 2'b10, 1'b0});
    tbl.push_back('{3'd6, 8'h95, 1'b1, 1'b1, 2'b11, 1'b0});
    tbl.push_back('{3'd6, 8'h95, 1'b1, 1'b1, 2'b01, 1'b0});
    tbl.push_back('{3'd6, 8'h95, 1'b1, 1'b1, 2'b00, 1'b0});
    tbl.push_back('{3'd6, 8'h95, 1'b0, 1'b1, 2'b10, 1'b1});
    tbl.push_back('{3'd7, 8'h3C, 1'b1, 1'b1, 2'b11, 1'b1});
    tbl.push_back('{3'd5, 8'hA6, 1'b0, 1'b0, 2'b00, 1'b0});
    foreach (tbl[t]) begin
      @(negedge clk);
      drive_cfg(tbl[t]);
      en = 1'b1; send = 1'b1;
      push_frame(tbl[t]);
      @(negedge clk);
      send = 1'b0;
      scramble();
      capture(div_of(tbl[t].mode), fst, lst, ufst, ulst, len, to);
      nb = exp_nb.pop_front();
      el = exp_len.pop_front();
      asserts++;
      if (to || len != el) begin fails++; $display("FAIL frame%0d_len: got %0d expected %0d", t, len, el); end
      for (int k = 0; k < nb; k++) begin
        eb = exp_bits.pop_front();
        asserts++;
        if (fst[k] !== eb || lst[k] !== eb) begin
          fails++;
          $display("FAIL frame%0d_bit%0d: got first=%b last=%b expected %b", t, k, fst[k], lst[k], eb);
        end
      end
      m = (12'h1 << nb) - 12'h1;
      asserts++;
      if ((ufst & m) !== m || (ulst & m) !== 12'h0) begin
        fails++;
        $display("FAIL frame%0d_uartclock: got high=%h low=%h expected high=%h low=0", t, ufst & m, ulst & m, m);
      end
    end
  endtask

  task automatic test_ignore_busy();
    cfg_t c;
    logic [11:0] fst, lst, ufst, ulst;
    int len, nb, el, bad;
    bit to;
    logic eb;
    c = '{3'd6, 8'h5A, 1'b1, 1'b1, 2'b10, 1'b0};
    @(negedge clk);
    drive_cfg(c);
    en = 1'b1; send = 1'b1;
    push_frame(c);
    @(negedge clk);
    send = 1'b0;
    fork
      capture(div_of(c.mode), fst, lst, ufst, ulst, len, to);
      begin
        repeat (1000) @(negedge clk);
        data = 8'hFF; send = 1'b1;
        @(negedge clk);
        send = 1'b0; en = 1'b0;
      end
    join
    nb = exp_nb.pop_front();
    el = exp_len.pop_front();
    asserts++;
    if (to || len != el) begin fails++; $display("FAIL busy_len: got %0d expected %0d", len, el); end
    for (int k = 0; k < nb; k++) begin
      eb = exp_bits.pop_front();
      asserts++;
      if (fst[k] !== eb || lst[k] !== eb) begin
        fails++;
        $display("FAIL busy_bit%0d: got first=%b last=%b expected %b", k, fst[k], lst[k], eb);
      end
    end
    send = 1'b1;
    bad = 0;
    repeat (30) begin
      @(negedge clk);
      if (tx !== 1'b1 || ready !== 1'b1) bad++;
    end
    asserts++;
    if (bad != 0) begin fails++; $display("FAIL en_low_blocks: got %0d non-idle cycles expected 0", bad); end
    send = 1'b0;
    en = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    cfg_t c;
    logic [11:0] fst, lst, ufst, ulst;
    int len, nb, el;
    bit to;
    logic eb;
    int bad;
    c = '{3'd7, 8'hC3, 1'b1, 1'b0, 2'b00, 1'b0};
    @(negedge clk);
    drive_cfg(c);
    en = 1'b1; send = 1'b1;
    push_frame(c);
    push_frame(c);
    for (int f = 0; f < 2; f++) begin
      if (f == 1) begin
        asserts++;
        if (tx !== 1'b1) begin fails++; $display("FAIL b2b_gap_tx: got %b expected 1", tx); end
        @(negedge clk);
        asserts++;
        if (ready !== 1'b0 || tx !== 1'b0) begin
          fails++;
          $display("FAIL b2b_gap_len: got ready=%b tx=%b expected ready=0 tx=0", ready, tx);
        end
        send = 1'b0;
      end
      capture(div_of(c.mode), fst, lst, ufst, ulst, len, to);
      nb = exp_nb.pop_front();
      el = exp_len.pop_front();
      asserts++;
      if (to || len != el) begin fails++; $display("FAIL b2b%0d_len: got %0d expected %0d", f, len, el); end
      for (int k = 0; k < nb; k++) begin
        eb = exp_bits.pop_front();
        asserts++;
        if (fst[k] !== eb || lst[k] !== eb) begin
          fails++;
          $display("FAIL b2b%0d_bit%0d: got first=%b last=%b expected %b", f, k, fst[k], lst[k], eb);
        end
      end
    end
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (tx !== 1'b1 || ready !== 1'b1) bad++;
    end
    asserts++;
    if (bad != 0) begin fails++; $display("FAIL b2b_no_third: got %0d non-idle cycles expected 0", bad); end
  endtask

  task automatic test_reset_midframe();
    cfg_t c;
    logic [11:0] fst, lst, ufst, ulst;
    int len, nb, el;
    bit to;
    logic eb;
    c = '{3'd6, 8'h00, 1'b1, 1'b0, 2'b00, 1'b1};
    @(negedge clk);
    drive_cfg(c);
    en = 1'b1; send = 1'b1;
    @(negedge clk);
    send = 1'b0;
    repeat (1000) @(negedge clk);
    asserts++;
    if (ready !== 1'b0 || tx !== 1'b0) begin
      fails++;
      $display("FAIL midframe_busy: got ready=%b tx=%b expected ready=0 tx=0", ready, tx);
    end
    rst = 1'b0;
    @(negedge clk);
    asserts++;
    if (tx !== 1'b1 || ready !== 1'b1 || uart_clock !== 1'b0) begin
      fails++;
      $display("FAIL midframe_reset: got tx=%b ready=%b uartclock=%b expected 1 1 0", tx, ready, uart_clock);
    end
    rst = 1'b1;
    @(negedge clk);
    c = '{3'd6, 8'h95, 1'b1, 1'b1, 2'b11, 1'b0};
    drive_cfg(c);
    send = 1'b1;
    push_frame(c);
    @(negedge clk);
    send = 1'b0;
    capture(div_of(c.mode), fst, lst, ufst, ulst, len, to);
    nb = exp_nb.pop_front();
    el = exp_len.pop_front();
    asserts++;
    if (to || len != el) begin fails++; $display("FAIL post_reset_len: got %0d expected %0d", len, el); end
    for (int k = 0; k < nb; k++) begin
      eb = exp_bits.pop_front();
      asserts++;
      if (fst[k] !== eb || lst[k] !== eb) begin
        fails++;
        $display("FAIL post_reset_bit%0d: got first=%b last=%b expected %b", k, fst[k], lst[k], eb);
      end
    end
  endtask

`ifdef UART_TX_BREAK_EN
  task automatic test_break();
    int bad;
    @(negedge clk);
    clk_mode = 3'd6;
    break_req = 1'b1;
    bad = 0;
    repeat (5000) begin
      if (tx !== 1'b0 || ready !== 1'b0) bad++;
      @(negedge clk);
    end
    asserts++;
    if (bad != 0) begin fails++; $display("FAIL break_hold: got %0d bad cycles expected 0", bad); end
    break_req = 1'b0;
    bad = 0;
    repeat (217) begin
      @(negedge clk);
      if (tx !== 1'b1 || ready !== 1'b0) bad++;
    end
    asserts++;
    if (bad != 0) begin fails++; $display("FAIL break_recover: got %0d bad cycles expected 0", bad); end
    @(negedge clk);
    asserts++;
    if (ready !== 1'b1) begin fails++; $display("FAIL break_ready: got %b expected 1", ready); end
  endtask
`endif

  initial begin
    test_reset();
    test_frames();
    test_ignore_busy();
    test_back_to_back();
    test_reset_midframe();
`ifdef UART_TX_BREAK_EN
    test_break();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL have parameter CLK_HZ, default 100000000, system clock frequency in Hz used to derive bit periods.
REQ-002 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port en  input  1  transmitter enable; gates acceptance of new frames.
REQ-005 SHALL have port clk_mode  input  3  baud select.
REQ-006 SHALL have port data_size  input  1  0: 7 data bits; 1: 8 data bits.
REQ-007 SHALL have port parity_en  input  1  1: parity bit appended.
REQ-008 SHALL have port parity_mode  input  2  11 odd, 10 even, 01 mark (1), 00 space (0).
REQ-009 SHALL have port stop_bit_size  input  1  0: one stop bit; 1: two stop bits.
REQ-010 SHALL have port data  input  8  byte to send; bit 7 ignored when data_size=0.
REQ-011 SHALL have port send  input  1  request to start a frame.
REQ-012 SHALL have port ready  output  1  high when idle and able to accept send.
REQ-013 SHALL have port tx  output  1  serial line, idle high.
REQ-014 SHALL have port uartClock  output  1  bit-rate square wave, high during first half of each bit period, low when idle.

Function
REQ-015 SHALL map clk_mode 0..7 to baud 9600, 19200, 38400, 57600, 115200, 230400, 460800, 921600; bit period DIV = CLK_HZ/baud, truncated (CLK_HZ=100 MHz: mode 0 = 10416, mode 6 = 217 cycles).
REQ-016 SHALL implement states IDLE, START, DATA, PARITY, STOP.
REQ-017 In IDLE: ready=1, tx=1; a cycle with send=1, en=1, ready=1 is an accept.
REQ-018 On accept SHALL latch data, data_size, parity_en, parity_mode, stop_bit_size, clk_mode; later input changes do not affect the frame in flight.
REQ-019 On the edge after accept: state START, ready=0, tx=0, bit counter cleared.
REQ-020 Each bit SHALL hold tx for exactly DIV clk cycles.
REQ-021 DATA SHALL send 7 or 8 bits LSB first.
REQ-022 PARITY (only if parity_en): even = XOR of sent data bits; odd = its inverse; mark = 1; space = 0.
REQ-023 STOP SHALL drive tx=1 for one or two bit periods, then return to IDLE with ready=1.
REQ-024 Total frame from tx falling edge to ready rising SHALL be (1 + 7|8 + 0|1 + 1|2) x DIV cycles.
REQ-025 send while ready=0 SHALL be ignored; no queuing.
REQ-026 en deasserted mid-frame SHALL NOT abort the frame; it only blocks the next accept.
REQ-027 send held high continuously SHALL start a new frame on the first IDLE cycle, giving back-to-back frames with exactly one idle cycle between.
REQ-028 uartClock SHALL derive from the same divider counter, phase-locked to each bit boundary.

Reset
REQ-029 With rst=0 at a rising edge: state IDLE, tx=1, ready=1, uartClock=0, all counters 0, latched config cleared.
REQ-030 Reset mid-frame SHALL abort immediately; tx=1 from the next edge, no partial-bit completion.

Configuration
REQ-031 Macro UART_TX_BREAK_EN defined: SHALL add input port break_req (1 bit); when asserted in IDLE, tx=0 and ready=0 while held; on deassertion, tx=1 for one full DIV period before ready=1; break_req during a frame is ignored until IDLE.
REQ-032 Macro UART_TX_BREAK_EN undefined: SHALL have no break_req port and no break logic.

Verification
REQ-033 clk_mode=6, data=8'h95, data_size=1, parity_en=0, stop_bit_size=0, pulse send -> tx: 0,1,0,1,0,1,0,0,1,1, each 217 cycles; ready high again 2170 cycles after tx falls.
REQ-034 Same byte, parity_en=1: mode 10 -> parity bit 0; mode 11 -> 1; mode 01 -> 1; mode 00 -> 0; frame 2387 cycles.
REQ-035 data=8'h95, data_size=0, parity even, stop_bit_size=1 -> 7 data bits 1,0,1,0,1,0,0, parity 1, two stop bits; frame 11x217 = 2387 cycles.
REQ-036 send held high, en=1 -> consecutive frames separated by exactly one cycle of ready=1, tx=1; send pulsed while ready=0 -> no effect.
REQ-037 rst=0 asserted 1000 cycles into a frame -> next edge tx=1, ready=1; subsequent send produces a full correct frame.
REQ-038 (UART_TX_BREAK_EN) break_req held 5000 cycles in IDLE -> tx=0 and ready=0 throughout; after release, tx=1 and ready=0 for 217 cycles, then ready=1.
